// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_loader_pkg;

    // Instruction word width, matching the core's instruction memory.
    localparam int unsigned INSTR_WIDTH    = 32;
    localparam int unsigned BYTES_PER_WORD = 4;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WRITE   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = IDLE,
        StCollect = COLLECT,
        StWrite   = WRITE,
        StDone    = DONE
    } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream big-endian into 32-bit words: first byte ends up in [31:24].
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic [7:0]             byte_in,
    output logic [INSTR_WIDTH-1:0] word,
    output logic                   word_ready
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [INSTR_WIDTH-1:0] shreg_q;
    logic [1:0]             count_q;

    assign word = shreg_q;
    // High in the cycle the final byte of a word is shifted in.
    assign word_ready = shift_en && (count_q == LAST_BYTE);

    // Shift register and byte counter; clear restarts word alignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (shift_en) begin
            shreg_q <= {shreg_q[INSTR_WIDTH-9:0], byte_in};
            count_q <= count_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory and holds the core in reset until done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH:0]    num_words,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                 state_q;
    logic [ADDR_WIDTH:0]    num_q;
    logic [ADDR_WIDTH-1:0]  idx_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [INSTR_WIDTH-1:0] wdata_q;
    logic                   error_q;

    logic                   start_ok;
    logic                   legal;
    logic                   accept;
    logic                   last_word;
    logic                   packer_clear;
    logic                   word_ready;
    logic [INSTR_WIDTH-1:0] packed_word;

    assign start_ok  = start && (state_q == StIdle || state_q == StDone);
    assign legal     = (num_words != '0) && (num_words <= MAX_WORDS);
    assign accept    = (state_q == StCollect) && rx_valid;
    assign last_word = ({1'b0, idx_q} == (num_q - 1'b1));
    // Realign on every new load and after every written word.
    assign packer_clear = (start_ok && legal) || (state_q == StWrite);

    // Outputs decoded from state only, so rx_ready never depends on rx_valid.
    assign rx_ready   = (state_q == StCollect);
    assign imem_we    = (state_q == StWrite);
    assign busy       = (state_q == StCollect) || (state_q == StWrite);
    assign done       = (state_q == StDone);
    assign cpu_hold   = (state_q != StDone);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign error      = error_q;

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (packer_clear),
        .shift_en   (accept),
        .byte_in    (rx_data),
        .word       (packed_word),
        .word_ready (word_ready)
    );

    // Load sequencer: word index, captured length, write-port registers and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            num_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        if (legal) begin
                            num_q   <= num_words;
                            idx_q   <= '0;
                            error_q <= 1'b0;
                            state_q <= StCollect;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
                StCollect: begin
                    if (word_ready) begin
                        // The fourth byte is still on rx_data; fold it in directly.
                        addr_q  <= idx_q;
                        wdata_q <= {packed_word[INSTR_WIDTH-9:0], rx_data};
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    if (last_word) begin
                        state_q <= StDone;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StCollect;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a small write log.
module tb_imem_loader;

    localparam int AW = 3;
    localparam int NMAX = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   num_words = '0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_words  (num_words),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // Log every write the memory would see.
    always @(posedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(32'(imem_addr));
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num_words = (AW+1)'(n);
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok = 1'b0;
        if (gap) begin
            rx_valid = 1'b0;
            tick(1);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        rx_valid = 1'b0;
        if (!ok) check_eq("byte_accept_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check_eq("done_reached", 32'(ok), 1);
    endtask

    task automatic send_prog_two(input bit gaps, input bit mid_start);
        logic [7:0] prog [8];
        prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        for (int i = 0; i < 8; i++) begin
            send_byte(prog[i], gaps && i[0]);
            if (mid_start && i == 2) do_start(1);
        end
    endtask

    task automatic check_two_writes(input string tag);
        check_eq({tag, "_nwr"}, 32'(wr_addr.size()), 2);
        if (wr_addr.size() == 2) begin
            check_eq({tag, "_addr0"}, wr_addr[0], 0);
            check_eq({tag, "_data0"}, wr_data[0], 32'h2008_0005);
            check_eq({tag, "_addr1"}, wr_addr[1], 1);
            check_eq({tag, "_data1"}, wr_data[1], 32'h0109_5020);
        end
    endtask

    initial begin
        // Reset and idle.
        tick(2);
        rst = 1'b0;
        tick(10);
        check_eq("idle_cpu_hold", 32'(cpu_hold), 1);
        check_eq("idle_rx_ready", 32'(rx_ready), 0);
        check_eq("idle_we", 32'(imem_we), 0);
        check_eq("idle_done", 32'(done), 0);
        check_eq("idle_error", 32'(error), 0);
        check_eq("idle_busy", 32'(busy), 0);

        // Two words, continuous stream.
        do_start(2);
        check_eq("load1_busy", 32'(busy), 1);
        check_eq("load1_rx_ready", 32'(rx_ready), 1);
        send_prog_two(1'b0, 1'b0);
        check_eq("load1_we_latency", 32'(imem_we), 1);
        wait_done();
        check_two_writes("load1");
        check_eq("load1_cpu_hold", 32'(cpu_hold), 0);
        check_eq("load1_busy_done", 32'(busy), 0);
        check_eq("load1_rx_ready_done", 32'(rx_ready), 0);
        check_eq("load1_wdata_hold", imem_wdata, 32'h0109_5020);
        check_eq("load1_addr_hold", 32'(imem_addr), 1);

        // Same load with gaps and an ignored mid-load start.
        wr_addr.delete();
        wr_data.delete();
        do_start(2);
        check_eq("load2_done_cleared", 32'(done), 0);
        check_eq("load2_cpu_hold", 32'(cpu_hold), 1);
        send_prog_two(1'b1, 1'b1);
        wait_done();
        tick(3);
        check_two_writes("load2");

        // Illegal lengths.
        wr_addr.delete();
        wr_data.delete();
        do_start(0);
        check_eq("zero_error", 32'(error), 1);
        check_eq("zero_cpu_hold", 32'(cpu_hold), 1);
        check_eq("zero_done", 32'(done), 0);
        tick(3);
        do_start(NMAX + 1);
        check_eq("over_error", 32'(error), 1);
        check_eq("over_busy", 32'(busy), 0);
        tick(5);
        check_eq("illegal_nwr", 32'(wr_addr.size()), 0);

        // Full-depth load; legal start clears error.
        do_start(NMAX);
        check_eq("full_error_cleared", 32'(error), 0);
        for (int w = 0; w < NMAX; w++) begin
            send_byte(8'(8'h10 + w), 1'b0);
            send_byte(8'(8'h20 + w), 1'b0);
            send_byte(8'(8'h30 + w), 1'b0);
            send_byte(8'(8'h40 + w), 1'b0);
        end
        wait_done();
        tick(4);
        check_eq("full_nwr", 32'(wr_addr.size()), NMAX);
        if (wr_addr.size() == NMAX) begin
            check_eq("full_last_addr", wr_addr[NMAX-1], NMAX - 1);
            check_eq("full_last_data", wr_data[NMAX-1], 32'h1727_3747);
            check_eq("full_addr3", wr_addr[3], 3);
            check_eq("full_data3", wr_data[3], 32'h1323_3343);
        end
        check_eq("full_done_stays", 32'(done), 1);

        // Reset in the middle of word 1.
        do_start(2);
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 1'b0);
        wr_addr.delete();
        wr_data.delete();
        rst = 1'b1;
        tick(1);
        check_eq("rst_rx_ready", 32'(rx_ready), 0);
        check_eq("rst_we", 32'(imem_we), 0);
        check_eq("rst_addr", 32'(imem_addr), 0);
        check_eq("rst_wdata", imem_wdata, 0);
        check_eq("rst_cpu_hold", 32'(cpu_hold), 1);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_error", 32'(error), 0);
        rst = 1'b0;
        tick(1);
        do_start(1);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        wait_done();
        check_eq("post_rst_nwr", 32'(wr_addr.size()), 1);
        if (wr_addr.size() == 1) begin
            check_eq("post_rst_addr", wr_addr[0], 0);
            check_eq("post_rst_data", wr_data[0], 32'hDEAD_BEEF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer for the instruction memory that the single-cycle MIPS core fetches and decodes from.
- Accepts a byte stream over a valid/ready interface and packs every 4 bytes, big-endian, into one 32-bit instruction word.
- Writes each word into consecutive instruction-memory addresses.
- Holds the core in reset until the requested number of words has been written.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width (depth 2^ADDR_WIDTH words)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE
num_words  input  ADDR_WIDTH+1  number of words to load; captured on accepted start
rx_data  input  8  incoming program byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction-memory write enable
imem_addr  output  ADDR_WIDTH  word address being written
imem_wdata  output  32  packed instruction word
cpu_hold  output  1  keeps the core in reset while high
busy  output  1  load in progress
done  output  1  load completed successfully
error  output  1  last start carried an illegal num_words

Behaviour:
- Reset values:
  - State is IDLE.
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, busy=0, done=0, error=0.
  - Byte counter=0, word index=0.
- States: IDLE, COLLECT, WRITE, DONE. Outputs are registered or decoded from state; no combinational path from rx_valid to rx_ready.
- IDLE:
  - cpu_hold=1.
  - start with 1 <= num_words <= 2^ADDR_WIDTH: capture num_words, clear word index, byte counter and error, go to COLLECT. busy=1 from the next cycle.
  - start with num_words==0 or num_words > 2^ADDR_WIDTH: error=1, stay in IDLE, no writes.
- COLLECT:
  - rx_ready=1.
  - Each cycle with rx_valid&rx_ready: shift rx_data into the low byte of a 32-bit shift register (previous contents shift left 8) and increment the byte counter.
  - The first byte of a word lands in bits [31:24].
  - When the 4th byte is accepted, go to WRITE.
  - rx_valid low: hold, no state change.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=word index, imem_wdata=assembled word, rx_ready=0.
  - Latency: the word is written the cycle after its 4th byte is accepted.
  - Then, if word index == captured num_words-1, go to DONE. Otherwise increment word index, clear byte counter, return to COLLECT.
  - The word index never wraps. The num_words check guarantees the last address is 2^ADDR_WIDTH-1 at most.
- DONE:
  - done=1, busy=0, cpu_hold=0, rx_ready=0. Incoming bytes are ignored.
  - A legal start re-enters COLLECT: cpu_hold=1 and done=0 on the next cycle. An illegal start sets error and returns to IDLE with cpu_hold=1.
- start while in COLLECT or WRITE is ignored.
- error stays high until the next accepted legal start or rst.
- rst mid-load: abort immediately to reset values. A partially assembled word is discarded; words already written stay in memory.
- imem_addr and imem_wdata hold their last values when imem_we=0.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE, COLLECT, WRITE, DONE);
  - the BYTES_PER_WORD=4 constant;
  - the instruction width constant (32), shared with the core's instruction memory.
- One natural sub-module, byte_packer: 32-bit shift register plus 2-bit byte counter, with a word_ready strobe. The top module keeps the FSM and address counter.

Test Plan:
- Reset, then idle 10 cycles -> cpu_hold=1, rx_ready=0, imem_we=0, done=0, error=0.
- start, num_words=2; bytes 0x20,0x08,0x00,0x05, 0x01,0x09,0x50,0x20 with rx_valid always high -> imem_we pulses twice:
  - addr 0, data 0x20080005;
  - addr 1, data 0x01095020;
  - then done=1, cpu_hold=0.
- Same load with rx_valid toggled every other cycle, and an extra start mid-load -> identical writes, start ignored, no stray imem_we.
- num_words=0, then num_words=2^ADDR_WIDTH+1 -> error=1, cpu_hold=1, no writes. A following legal start clears error.
- num_words=2^ADDR_WIDTH with a full byte stream -> last write at addr 2^ADDR_WIDTH-1, then DONE, no wrap to 0.
- rst asserted after 2 bytes of word 1 -> all outputs at reset values next cycle. A new load of 1 word writes addr 0 with only post-reset bytes.
